mips_mem_arbiter: RTL and testbench

- Shares one external memory port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage MIPS pipeline.
- Owns arbitration, latches each request, and handshakes with a variable-latency memory.
- Returns read data with a one-cycle done pulse and drives per-stage stall signals.
- Aborts transactions that exceed a timeout and flags a sticky bus error.

---
 rtl/mips_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mips_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and the
// load/store stage; data requests win, transactions time out into a sticky bus error.
module mips_mem_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          res,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    input  logic [3:0]    dm_be,
    output logic          dm_done,
    output logic [31:0]   dm_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          bus_err
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_reg;
    logic            owner_dm_reg;
    logic [CW-1:0]   cnt_reg;
    logic            if_done_reg;
    logic            dm_done_reg;
    logic [31:0]     if_rdata_reg;
    logic [31:0]     dm_rdata_reg;
    logic            mem_req_reg;
    logic            mem_we_reg;
    logic [AW-1:0]   mem_addr_reg;
    logic [31:0]     mem_wdata_reg;
    logic [3:0]      mem_be_reg;
    logic            bus_err_reg;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_reg     <= IDLE;
            owner_dm_reg  <= 1'b0;
            cnt_reg       <= '0;
            if_done_reg   <= 1'b0;
            dm_done_reg   <= 1'b0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
            bus_err_reg   <= 1'b0;
        end else begin
            if_done_reg <= 1'b0;
            dm_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Data side wins: it carries the older instruction in the pipeline.
                    if (dm_req) begin
                        owner_dm_reg  <= 1'b1;
                        mem_we_reg    <= dm_we;
                        mem_addr_reg  <= dm_addr;
                        mem_wdata_reg <= dm_wdata;
                        mem_be_reg    <= dm_be;
                        mem_req_reg   <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= BUSY;
                    end else if (if_req) begin
                        owner_dm_reg  <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= if_addr;
                        mem_be_reg    <= 4'hF;
                        mem_req_reg   <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= RESP;
                        if (owner_dm_reg) begin
                            dm_done_reg <= 1'b1;
                            if (!mem_we_reg) dm_rdata_reg <= mem_rdata;
                        end else begin
                            if_done_reg  <= 1'b1;
                            if_rdata_reg <= mem_rdata;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        // Abort: owner still gets its done pulse, with zeroed data.
                        mem_req_reg <= 1'b0;
                        bus_err_reg <= 1'b1;
                        state_reg   <= RESP;
                        if (owner_dm_reg) begin
                            dm_done_reg  <= 1'b1;
                            dm_rdata_reg <= '0;
                        end else begin
                            if_done_reg  <= 1'b1;
                            if_rdata_reg <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign if_done   = if_done_reg;
    assign dm_done   = dm_done_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;
    assign bus_err   = bus_err_reg;
    assign stall_if  = if_req & ~if_done_reg;
    assign stall_mem = dm_req & ~dm_done_reg;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a table of single transactions plus
// hand-written conflict, timeout/late-ack, mid-transaction reset and back-to-back sequences.
module tb_mips_mem_arbiter;
    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;
    logic        exp_err = 1'b0;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.AW(32), .TIMEOUT(16)) dut (
        .clk(clk), .res(res),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    typedef struct {
        logic        dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_at;     // BUSY cycle in which memory acks; 0 = never
        logic [31:0] mem_data;
        int          exp_busy;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_be;
    } txn_t;

    txn_t txns [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drives one request at a negedge, plays the memory, and checks every cycle until done.
    task automatic run_txn(input txn_t t, input string tag);
        int   busy;
        int   k;
        bit   seen_done;
        if (t.dm) begin
            dm_req = 1'b1; dm_we = t.we; dm_addr = t.addr; dm_wdata = t.wdata; dm_be = t.be;
        end else begin
            if_req = 1'b1; if_addr = t.addr;
        end
        #1;
        chk({tag, "_stall_req"}, t.dm ? stall_mem : stall_if, 1);
        busy = 0;
        seen_done = 0;
        k = 0;
        while (k < 40 && !seen_done) begin
            k++;
            step();
            mem_ack = 1'b0;
            if (mem_req) begin
                busy++;
                chk({tag, "_mem_addr"}, mem_addr, t.addr);
                chk({tag, "_mem_we"}, mem_we, t.we);
                chk({tag, "_mem_be"}, mem_be, t.exp_be);
                if (t.we) chk({tag, "_mem_wdata"}, mem_wdata, t.wdata);
                chk({tag, "_stall_busy"}, t.dm ? stall_mem : stall_if, 1);
                chk({tag, "_done_busy"}, {if_done, dm_done}, 2'b00);
                if (t.ack_at != 0 && busy == t.ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = t.mem_data;
                end
            end else begin
                seen_done = 1;
                chk({tag, "_busy_cycles"}, busy, t.exp_busy);
                chk({tag, "_done"}, {if_done, dm_done}, t.dm ? 2'b01 : 2'b10);
                chk({tag, "_stall_done"}, t.dm ? stall_mem : stall_if, 0);
                if (t.dm) exp_dm_rdata = t.exp_rdata;
                else      exp_if_rdata = t.exp_rdata;
                chk({tag, "_dm_rdata"}, dm_rdata, exp_dm_rdata);
                chk({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
                exp_err = exp_err | t.exp_err;
                chk({tag, "_bus_err"}, bus_err, exp_err);
                if_req = 1'b0;
                dm_req = 1'b0;
            end
        end
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL %s_no_done actual=none required=done_within_40", tag);
            if_req = 1'b0;
            dm_req = 1'b0;
        end
        step();
        chk({tag, "_idle_after"}, {mem_req, if_done, dm_done}, 3'b000);
        $display("txn %s dm=%0b we=%0b addr=%h busy=%0d if_rdata=%h dm_rdata=%h bus_err=%0b",
                 tag, t.dm, t.we, t.addr, busy, if_rdata, dm_rdata, bus_err);
    endtask

    initial begin
        txns[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 1, 32'h2008_000A, 1,  32'h2008_000A, 1'b0, 4'hF};
        txns[1] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         4'hF, 2, 32'h1357_2468, 2,  32'h1357_2468, 1'b0, 4'hF};
        txns[2] = '{1'b1, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4'h3, 3, 32'hDEAD_BEEF, 3,  32'h1357_2468, 1'b0, 4'h3};
        txns[3] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 2, 32'h8C01_0004, 2,  32'h8C01_0004, 1'b0, 4'hF};
        txns[4] = '{1'b1, 1'b0, 32'h0000_2FFC, 32'h0,         4'hC, 1, 32'hA5A5_0000, 1,  32'hA5A5_0000, 1'b0, 4'hC};
        txns[5] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         4'hF, 0, 32'h0,         16, 32'h0,         1'b1, 4'hF};

        // Reset state
        step();
        step();
        chk("reset_outputs", {if_done, dm_done, mem_req, mem_we, mem_be, bus_err, stall_if, stall_mem}, 0);
        chk("reset_data", {if_rdata, dm_rdata, mem_addr}, 0);
        res = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_txn(txns[i], $sformatf("vec%0d", i));
        end

        // Late ack while idle must not touch anything
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        step();
        chk("late_ack_ctrl", {mem_req, if_done, dm_done, bus_err}, 4'b0001);
        chk("late_ack_data", {if_rdata, dm_rdata}, {exp_if_rdata, exp_dm_rdata});
        $display("txn late_ack mem_req=%0b dm_rdata=%h bus_err=%0b", mem_req, dm_rdata, bus_err);

        // Reset in the second BUSY cycle of a fetch
        if_req = 1'b1;
        if_addr = 32'h0000_0080;
        step();
        chk("rst_mid_busy1", mem_req, 1);
        step();
        chk("rst_mid_busy2", mem_req, 1);
        res = 1'b1;
        #1;
        chk("rst_mid_async", {mem_req, if_done, bus_err}, 3'b000);
        chk("rst_mid_rdata", {if_rdata, dm_rdata}, 0);
        if_req = 1'b0;
        step();
        res = 1'b0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        exp_err = 1'b0;
        step();
        $display("txn reset_mid mem_req=%0b bus_err=%0b", mem_req, bus_err);
        run_txn('{1'b0, 1'b0, 32'h0000_0084, 32'h0, 4'h0, 2, 32'h03E0_0008, 2, 32'h03E0_0008, 1'b0, 4'hF}, "post_rst");

        // Conflict: data load wins, fetch follows after the IDLE return
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000; dm_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        step();
        chk("conf_first_addr", {mem_req, mem_addr, mem_we}, {1'b1, 32'h0000_2000, 1'b0});
        chk("conf_stall_if1", stall_if, 1);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0;
        chk("conf_dm_done", {if_done, dm_done, mem_req}, 3'b010);
        chk("conf_dm_rdata", dm_rdata, 32'h1111_2222);
        chk("conf_stall_if2", stall_if, 1);
        dm_req = 1'b0;
        step();
        chk("conf_idle", {mem_req, stall_if}, 2'b01);
        step();
        chk("conf_second", {mem_req, mem_addr, mem_be}, {1'b1, 32'h0000_0200, 4'hF});
        chk("conf_stall_if3", stall_if, 1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0020;
        step();
        mem_ack = 1'b0;
        chk("conf_if_done", {if_done, dm_done}, 2'b10);
        chk("conf_if_rdata", if_rdata, 32'h0000_0020);
        if_req = 1'b0;
        step();
        $display("txn conflict dm_rdata=%h if_rdata=%h", dm_rdata, if_rdata);

        // Back-to-back fetches with if_req held across if_done
        begin
            int done_cyc [2];
            int nd;
            int cyc;
            nd = 0;
            if_req = 1'b1;
            if_addr = 32'h0000_0040;
            for (cyc = 1; cyc <= 8 && nd < 2; cyc++) begin
                step();
                mem_ack = 1'b0;
                if (mem_req) begin
                    chk($sformatf("b2b_addr%0d", nd), mem_addr, nd == 0 ? 32'h0000_0040 : 32'h0000_0044);
                    mem_ack = 1'b1;
                    mem_rdata = nd == 0 ? 32'h0000_0001 : 32'h0000_0002;
                end else if (if_done) begin
                    chk($sformatf("b2b_rdata%0d", nd), if_rdata, nd == 0 ? 32'h0000_0001 : 32'h0000_0002);
                    done_cyc[nd] = cyc;
                    nd++;
                    if_addr = 32'h0000_0044;
                    if (nd == 2) if_req = 1'b0;
                end
            end
            chk("b2b_done_count", nd, 2);
            if (nd == 2) chk("b2b_spacing", done_cyc[1] - done_cyc[0], 3);
            step();
            chk("b2b_idle", {mem_req, if_done}, 2'b00);
            $display("txn back_to_back dones=%0d if_rdata=%h", nd, if_rdata);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule
